// File: rtl/if_prefetch_stage.sv
// Instruction-fetch prefetch queue: issues sequential reads to instruction memory
// and buffers {address + PC_STEP, instruction} pairs. Optional macro: IF_STALL_COUNT_EN.
module if_prefetch_stage #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int DEPTH   = 4,
   parameter int PC_STEP = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         freeze,
   input  logic                         flush,
   input  logic                         Branch_Tacken,
   input  logic [ADDR_W-1:0]            Branch_Address,
   output logic                         imem_req,
   output logic [ADDR_W-1:0]            imem_addr,
   input  logic [DATA_W-1:0]            imem_rdata,
   input  logic                         imem_rvalid,
   output logic [ADDR_W-1:0]            PC,
   output logic [DATA_W-1:0]            Instruction,
   output logic                         valid,
   output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef IF_STALL_COUNT_EN
   ,
   output logic [31:0]                  stall_count
`endif
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(DEPTH);

   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] req_addr_p1;
   logic              req_vld_p1;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W:0]    occ;
   logic              kill;
   logic              push;
   logic              pop;

   logic [ADDR_W-1:0] q_pc  [DEPTH];
   logic [DATA_W-1:0] q_ins [DEPTH];

   // Occupancy includes the outstanding read so a returning response always has a slot.
   assign kill      = flush | Branch_Tacken;
   assign occ       = {1'b0, cnt} + {{CNT_W{1'b0}}, req_vld_p1};
   assign imem_req  = rst & ~kill & (occ < DEPTH_V);
   assign imem_addr = fetch_pc;

   assign push = rst & ~kill & imem_rvalid & req_vld_p1;
   assign pop  = rst & ~kill & valid & ~freeze;

   assign valid       = (cnt != '0);
   assign count       = cnt;
   assign PC          = valid ? q_pc[rd_ptr]  : '0;
   assign Instruction = valid ? q_ins[rd_ptr] : '0;

   // Stage p0 -> p1: request issue and queue control.
   always_ff @(posedge clk) begin
      if (!rst) begin
         fetch_pc    <= '0;
         req_vld_p1  <= 1'b0;
         req_addr_p1 <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         cnt         <= '0;
      end else begin
         req_vld_p1 <= imem_req;
         if (imem_req) begin
            req_addr_p1 <= fetch_pc;
            fetch_pc    <= fetch_pc + ADDR_W'(PC_STEP);
         end
         if (Branch_Tacken) begin
            fetch_pc <= Branch_Address;
         end
         if (kill) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
               2'b10:   cnt <= cnt + CNT_W'(1);
               2'b01:   cnt <= cnt - CNT_W'(1);
               default: cnt <= cnt;
            endcase
         end
      end
   end

   // Stage p1 -> queue: response capture (storage needs no reset, guarded by cnt).
   always_ff @(posedge clk) begin
      if (push) begin
         q_pc[wr_ptr]  <= req_addr_p1 + ADDR_W'(PC_STEP);
         q_ins[wr_ptr] <= imem_rdata;
      end
   end

`ifdef IF_STALL_COUNT_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_count <= '0;
      end else if (valid && freeze) begin
         stall_count <= sat_inc(stall_count);
      end
   end
`endif

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed bench for if_prefetch_stage with a one-cycle-latency memory returning addr/4.
module tb_if_prefetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        freeze;
   logic        flush;
   logic        Branch_Tacken;
   logic [31:0] Branch_Address;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_rvalid;
   logic [31:0] PC;
   logic [31:0] Instruction;
   logic        valid;
   logic [2:0]  count;
`ifdef IF_STALL_COUNT_EN
   logic [31:0] stall_count;
`endif
   logic        inject;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   if_prefetch_stage dut (
      .clk            (clk),
      .rst            (rst),
      .freeze         (freeze),
      .flush          (flush),
      .Branch_Tacken  (Branch_Tacken),
      .Branch_Address (Branch_Address),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .imem_rvalid    (imem_rvalid),
      .PC             (PC),
      .Instruction    (Instruction),
      .valid          (valid),
      .count          (count)
`ifdef IF_STALL_COUNT_EN
      ,
      .stall_count    (stall_count)
`endif
   );

   // Memory model: response one cycle after each request; inject forces a stray response.
   always @(posedge clk) begin
      imem_rvalid <= imem_req | inject;
      imem_rdata  <= imem_addr >> 2;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; freeze = 1'b0; flush = 1'b0; Branch_Tacken = 1'b0;
      Branch_Address = '0; inject = 1'b0;
      step(2);
      #1;
      chk("rst_req", imem_req, 0);
      chk("rst_valid", valid, 0);
      chk("rst_count", count, 0);
      chk("rst_pc", PC, 0);
      chk("rst_ins", Instruction, 0);

      rst = 1'b1; #1;
      chk("rel_req", imem_req, 1);
      chk("rel_addr", imem_addr, 0);
      step(1);
      chk("c1_valid", valid, 0);
      chk("c1_addr", imem_addr, 4);
      step(1);
      chk("c2_valid", valid, 1);
      chk("c2_pc", PC, 4);
      chk("c2_ins", Instruction, 0);
      chk("c2_count", count, 1);
      step(1);
      chk("c3_pc", PC, 8);
      chk("c3_ins", Instruction, 1);
      step(1);
      chk("c4_pc", PC, 12);
      chk("c4_ins", Instruction, 2);

      // Freeze: prefetch continues until queue plus in-flight reaches DEPTH.
      freeze = 1'b1; #1;
      chk("frz_req", imem_req, 1);
      chk("frz_addr", imem_addr, 16);
      step(2);
      chk("frz_full_req", imem_req, 0);
      chk("frz_full_addr", imem_addr, 24);
      step(1);
      chk("frz_count", count, 4);
      chk("frz_req_hold", imem_req, 0);
      step(1);
      inject = 1'b1;
      step(1);
      inject = 1'b0;
      step(1);
      chk("stray_count", count, 4);
      chk("stray_pc", PC, 12);
      chk("stray_ins", Instruction, 2);
      step(3);
      freeze = 1'b0; #1;
      chk("unfrz_req", imem_req, 0);
      step(1);
      chk("unfrz_pc", PC, 16);
      chk("unfrz_ins", Instruction, 3);
      chk("unfrz_count", count, 3);
      chk("unfrz_req2", imem_req, 1);
      chk("unfrz_addr", imem_addr, 24);
`ifdef IF_STALL_COUNT_EN
      chk("stall_9", stall_count, 9);
`endif
      step(1);
      chk("s15_pc", PC, 20);
      chk("s15_ins", Instruction, 4);
      step(1);
      chk("s16_pc", PC, 24);
      chk("s16_count", count, 2);
      step(1);
      chk("s17_pc", PC, 28);
      chk("s17_ins", Instruction, 6);
      step(1);
      chk("s18_pc", PC, 32);
      chk("s18_ins", Instruction, 7);

      // Redirect while full with a request in flight.
      freeze = 1'b1;
      step(1);
      chk("full_count", count, 3);
      chk("full_req", imem_req, 0);
      Branch_Tacken = 1'b1; Branch_Address = 32'h100; #1;
      chk("br_req", imem_req, 0);
      step(1);
      Branch_Tacken = 1'b0; freeze = 1'b0; #1;
      chk("br_valid", valid, 0);
      chk("br_count", count, 0);
      chk("br_req2", imem_req, 1);
      chk("br_addr", imem_addr, 32'h100);
      step(1);
      chk("br1_valid", valid, 0);
      step(1);
      chk("br2_valid", valid, 1);
      chk("br2_pc", PC, 32'h104);
      chk("br2_ins", Instruction, 32'h40);

      // Flush: fetch PC holds, killed in-flight address is not refetched.
      flush = 1'b1; #1;
      chk("fl_req", imem_req, 0);
      chk("fl_addr", imem_addr, 32'h108);
      step(1);
      flush = 1'b0; #1;
      chk("fl_valid", valid, 0);
      chk("fl_count", count, 0);
      chk("fl_req2", imem_req, 1);
      chk("fl_addr2", imem_addr, 32'h108);
      step(1);
      chk("fl1_valid", valid, 0);
      step(1);
      chk("fl2_pc", PC, 32'h10C);
      chk("fl2_ins", Instruction, 32'h42);

      // Redirect to the top of the address space wraps to 0.
      Branch_Tacken = 1'b1; Branch_Address = 32'hFFFF_FFFC;
      step(1);
      Branch_Tacken = 1'b0; #1;
      chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
      chk("wr_valid", valid, 0);
      step(1);
      chk("wr_addr2", imem_addr, 0);
      step(1);
      chk("wr_pc", PC, 0);
      chk("wr_ins", Instruction, 32'h3FFF_FFFF);
      step(1);
      chk("wr2_pc", PC, 4);
      chk("wr2_ins", Instruction, 0);

      // One-cycle reset mid-stream with freeze held.
      freeze = 1'b1; rst = 1'b0; #1;
      chk("mr_req", imem_req, 0);
      step(1);
      rst = 1'b1; #1;
      chk("mr_valid", valid, 0);
      chk("mr_count", count, 0);
      chk("mr_pc", PC, 0);
      chk("mr_ins", Instruction, 0);
      chk("mr_req2", imem_req, 1);
      chk("mr_addr", imem_addr, 0);
`ifdef IF_STALL_COUNT_EN
      chk("stall_rst", stall_count, 0);
`endif
      step(1);
      chk("mr1_valid", valid, 0);
      step(1);
      chk("mr2_valid", valid, 1);
      chk("mr2_pc", PC, 4);
      chk("mr2_count", count, 1);
      step(1);
      chk("mr3_count", count, 2);
      chk("mr3_pc", PC, 4);
`ifdef IF_STALL_COUNT_EN
      chk("stall_1", stall_count, 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/if_prefetch_stage.md
IF_PREFETCH_STAGE -- requirements
Module: if_prefetch_stage

Interface
REQ-001 SHALL have parameters: ADDR_W, 32, address/PC width; DATA_W, 32, instruction width; DEPTH, 4, queue entries (power of two, >=2); PC_STEP, 4, fetch address increment.
REQ-002 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-003 rst  in  1  synchronous active-low reset.
REQ-004 freeze  in  1  downstream hold, no pop while high.
REQ-005 flush  in  1  discard queue and in-flight fetch, fetch PC unchanged.
REQ-006 Branch_Tacken  in  1  redirect: discard as flush, fetch PC <= Branch_Address.
REQ-007 Branch_Address  in  ADDR_W  redirect target.
REQ-008 imem_req  out  1  read request this cycle.
REQ-009 imem_addr  out  ADDR_W  read address, equal to fetch PC.
REQ-010 imem_rdata  in  DATA_W  read data, valid when imem_rvalid high.
REQ-011 imem_rvalid  in  1  response, exactly one cycle after each imem_req.
REQ-012 PC  out  ADDR_W  head entry address + PC_STEP.
REQ-013 Instruction  out  DATA_W  head entry instruction.
REQ-014 valid  out  1  queue non-empty.
REQ-015 count  out  $clog2(DEPTH+1)  current occupancy.

Function
REQ-016 Circular queue of DEPTH entries {fetch address + PC_STEP, instruction}; read/write pointers wrap modulo DEPTH.
REQ-017 imem_req SHALL be high iff count + inflight < DEPTH and neither flush nor Branch_Tacken is high; inflight = 1 when imem_req was high last cycle and not killed.
REQ-018 Each accepted request: fetch PC <= fetch PC + PC_STEP (modulo 2^ADDR_W, wrap silently).
REQ-019 Push on imem_rvalid when the matching request is not killed; entry address = address of that request.
REQ-020 Pop when valid and freeze low; PC/Instruction SHALL be combinational from head entry; both 0 when empty.
REQ-021 Push and pop same cycle: count unchanged, both pointers advance.
REQ-022 Freeze does not stop prefetch; fetching stops only when full (count + inflight = DEPTH) and resumes the cycle after a pop frees space.
REQ-023 flush or Branch_Tacken: next cycle count = 0, pointers reset to 0, pending response killed (its imem_rvalid ignored), no pop/push that cycle.
REQ-024 Branch_Tacken: fetch PC <= Branch_Address; first request at that address issued the cycle after the redirect; Branch_Tacken and flush together behave as Branch_Tacken.
REQ-025 Priority: rst > Branch_Tacken > flush > push/pop.
REQ-026 Overflow impossible by REQ-017; imem_rvalid without matching live request SHALL be ignored.

Reset
REQ-027 rst low at a clk edge: fetch PC = 0, pointers = 0, count = 0, inflight = 0, valid = 0, PC = 0, Instruction = 0, imem_req = 0 during reset.
REQ-028 Reset mid-operation discards queue and in-flight response; first request (address 0) issued the first cycle rst is high.

Configuration
REQ-029 Macro IF_STALL_COUNT_EN: when defined, adds output stall_count (32 bits), reset 0, incrementing each cycle valid and freeze both high, saturating at all-ones, cleared by rst only.
REQ-030 Without IF_STALL_COUNT_EN: port and counter absent, all other behaviour identical.

Verification
REQ-031 Reset release, memory returns addr/4 as data, freeze low -> requests 0,4,8,...; first valid 2 cycles after release with PC=4, Instruction=0; one instruction per cycle thereafter.
REQ-032 freeze high 10 cycles, DEPTH=4 -> imem_req drops after 4 outstanding+stored, count=4, head held PC=4; freeze low -> pops resume, fetch restarts next cycle, no address skipped or duplicated.
REQ-033 Branch_Tacken with Branch_Address=0x100 while full and a request in flight -> next cycle valid=0, count=0, stale rvalid ignored, imem_addr=0x100; first valid PC=0x104.
REQ-034 flush alone at fetch PC 0x20 -> queue empty, next request 0x20 (killed in-flight address not refetched).
REQ-035 rst low for one cycle mid-stream with freeze high -> all outputs 0, refetch from 0; with IF_STALL_COUNT_EN stall_count=0 then counts frozen cycles exactly.
REQ-036 Branch_Address=0xFFFFFFFC -> fetch wraps to 0x0; head PC output of that entry = 0x0.
